store_demux: RTL

Write-side counterpart of the datapath 2:1 mux. It takes the single store stream from the MIPS core's MEM stage and routes each write to exactly one sink: data memory, the LED register or the seven-segment register. Every routed write is registered. Illegal stores are dropped and logged. The block sits between the core and the Basys3 memory/IO fabric.

---
 rtl/store_map_pkg.sv | 25 ++
 rtl/store_addr_decode.sv | 35 +++
 rtl/store_demux.sv | 95 +++++++++
 3 files changed

// File: rtl/store_map_pkg.sv
// store_map_pkg
//   Shared address-map definitions for the store demux slice: default
//   byte addresses of the memory-mapped IO registers, the decoded store
//   target type, and the mask of address bits that must be zero for a
//   data-memory store in the default map.
package store_map_pkg;

   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_DMEM_AW = 10;

   localparam logic [31:0] LED_ADDR_DEFAULT = 32'hFFFF_0000;
   localparam logic [31:0] SEG_ADDR_DEFAULT = 32'hFFFF_0004;

   // Bits above the word-address field plus byte offset; any one set means
   // the address lies outside data memory (default map: 32'hFFFF_F000).
   localparam logic [31:0] DMEM_HI_MASK = 32'hFFFF_FFFF << (DEF_DMEM_AW + 2);

   typedef enum logic [1:0] {
      TGT_NONE = 2'd0,
      TGT_DMEM = 2'd1,
      TGT_LED  = 2'd2,
      TGT_SEG  = 2'd3
   } target_e;

endpackage

// File: rtl/store_addr_decode.sv
// store_addr_decode
//   Combinational store-address decoder. Selects at most one sink for a
//   byte address and flags byte offsets that are not word aligned.
//   Ports:
//     addr        in   WIDTH   byte address of the store
//     tgt         out  enum    decoded sink (TGT_NONE when unmapped)
//     misaligned  out  1       addr[1:0] != 0
module store_addr_decode
   import store_map_pkg::*;
#(
   parameter int unsigned       WIDTH    = DEF_WIDTH,
   parameter int unsigned       DMEM_AW  = DEF_DMEM_AW,
   parameter logic [WIDTH-1:0]  LED_ADDR = LED_ADDR_DEFAULT,
   parameter logic [WIDTH-1:0]  SEG_ADDR = SEG_ADDR_DEFAULT
) (
   input  logic [WIDTH-1:0] addr,
   output target_e          tgt,
   output logic             misaligned
);

   // Width-generic version of the package's DMEM_HI_MASK.
   localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << (DMEM_AW + 2);

   always_comb begin
      tgt        = TGT_NONE;
      misaligned = (addr[1:0] != 2'b00);
      if ((addr & HI_MASK) == '0)
         tgt = TGT_DMEM;
      else if (addr == LED_ADDR)
         tgt = TGT_LED;
      else if (addr == SEG_ADDR)
         tgt = TGT_SEG;
   end

endmodule

// File: rtl/store_demux.sv
// store_demux
//   Routes the MEM-stage store stream to exactly one sink (data memory,
//   LED register, seven-segment register). All sink outputs are registered
//   with one cycle of latency. Unmapped or misaligned stores are dropped,
//   raise a sticky error and record the first offending address.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     wr_en        store request (single-cycle)
//     addr, wdata  store byte address / data
//     dmem_we      registered data-memory write strobe
//     dmem_addr    registered word address addr[DMEM_AW+1:2]
//     dmem_wdata   registered data-memory write data
//     led_reg      LED register (wdata[15:0])
//     seg_reg      seven-segment register (wdata[15:0])
//     bad_addr     sticky illegal-store flag
//     err_addr     address of the first dropped store
//     store_cnt    wrapping count of accepted stores
module store_demux
   import store_map_pkg::*;
#(
   parameter int unsigned       WIDTH    = DEF_WIDTH,
   parameter int unsigned       DMEM_AW  = DEF_DMEM_AW,
   parameter logic [WIDTH-1:0]  LED_ADDR = LED_ADDR_DEFAULT,
   parameter logic [WIDTH-1:0]  SEG_ADDR = SEG_ADDR_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   addr,
   input  logic [WIDTH-1:0]   wdata,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [WIDTH-1:0]   dmem_wdata,
   output logic [15:0]        led_reg,
   output logic [15:0]        seg_reg,
   output logic               bad_addr,
   output logic [WIDTH-1:0]   err_addr,
   output logic [15:0]        store_cnt
);

   target_e tgt;
   logic    misaligned;
   logic    legal;
   logic    illegal;

   store_addr_decode #(
      .WIDTH    (WIDTH),
      .DMEM_AW  (DMEM_AW),
      .LED_ADDR (LED_ADDR),
      .SEG_ADDR (SEG_ADDR)
   ) u_decode (
      .addr       (addr),
      .tgt        (tgt),
      .misaligned (misaligned)
   );

   always_comb begin
      legal   = wr_en && (tgt != TGT_NONE) && !misaligned;
      illegal = wr_en && !legal;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         led_reg    <= '0;
         seg_reg    <= '0;
         bad_addr   <= 1'b0;
         err_addr   <= '0;
         store_cnt  <= '0;
      end else begin
         dmem_we <= legal && (tgt == TGT_DMEM);
         if (legal) begin
            store_cnt <= store_cnt + 16'd1;
            unique case (tgt)
               TGT_DMEM: begin
                  dmem_addr  <= addr[DMEM_AW+1:2];
                  dmem_wdata <= wdata;
               end
               TGT_LED:  led_reg <= wdata[15:0];
               TGT_SEG:  seg_reg <= wdata[15:0];
               default:  ;
            endcase
         end
         if (illegal) begin
            bad_addr <= 1'b1;
            // First error wins: capture only while the flag is still clear.
            if (!bad_addr)
               err_addr <= addr;
         end
      end
   end

endmodule
